gbuff_out_checker: RTL and testbench

//  Parametrised self-checking scoreboard for the TPU output global buffer.

---
 rtl/gbuff_out_checker_pkg.sv | 28 ++
 rtl/gbuff_lane_cmp.sv | 28 ++
 rtl/gbuff_out_checker.sv | 192 +++++++++++++++++++
 tb/tb_gbuff_out_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gbuff_out_checker_pkg.sv
// rtl/gbuff_out_checker_pkg.sv - shared types and helpers for the output global-buffer checker
// Purpose: FSM state encoding, width helper and golden-lane mapping used by
//          gbuff_out_checker and gbuff_lane_cmp.
// Ports:   none (package).
package gbuff_out_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DONE = 3'd1,
    ST_SCAN      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_REPORT    = 3'd4
  } state_t;

  // ceil(log2(value)) but never below 1, so one-lane or tiny-limit builds still get a real vector
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  // Golden lane that out lane j is compared against
  function automatic int gold_lane(input int j, input int lanes, input int reverse);
    return (reverse != 0) ? (lanes - 1 - j) : j;
  endfunction

endpackage

// File: rtl/gbuff_lane_cmp.sv
// rtl/gbuff_lane_cmp.sv - combinational lane-by-lane word comparator with lane mask
// Purpose: flags every unmasked out lane whose value differs from its golden counterpart.
// Ports:   i_out_word  GBUFF_OUT word
//          i_gold_word golden word
//          i_lane_mask 1 = lane takes part in the compare
//          o_mismatch  per out-lane mismatch flags
module gbuff_lane_cmp
  import gbuff_out_checker_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int REVERSE = 1
) (
  input  logic [LANES*DATA_W-1:0] i_out_word,
  input  logic [LANES*DATA_W-1:0] i_gold_word,
  input  logic [LANES-1:0]        i_lane_mask,
  output logic [LANES-1:0]        o_mismatch
);

  always_comb begin
    o_mismatch = '0;
    for (int j = 0; j < LANES; j++) begin
      o_mismatch[j] = i_lane_mask[j] &&
        (i_out_word[j*DATA_W +: DATA_W] != i_gold_word[gold_lane(j, LANES, REVERSE)*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/gbuff_out_checker.sv
// rtl/gbuff_out_checker.sv - self-checking scoreboard for the TPU output global buffer
// Purpose: arms on start, waits for done_i or watchdog, walks GBUFF_OUT and golden
//          memory one word per cycle and accumulates lane mismatches.
// Ports:   clk, rst_n (sync, active low), start/m/n arm and dimensions, done_i TPU done,
//          out_addr/out_rdata and gold_addr/gold_rdata buffer read ports (1-cycle latency),
//          busy, check_done, pass, timeout, err_count, first_err_addr, first_err_lane results.
module gbuff_out_checker
  import gbuff_out_checker_pkg::*;
#(
  parameter int  DATA_W     = 8,
  parameter int  LANES      = 4,
  parameter int  ADDR_W     = 8,
  parameter int  DIM_W      = 4,
  parameter int  CNT_W      = 16,
  parameter int  MAX_CYCLES = 4096,
  parameter int  REVERSE    = 1,
  localparam int LANE_W     = clog2_min1(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIM_W-1:0]          m,
  input  logic [DIM_W-1:0]          n,
  input  logic                      done_i,
  output logic [ADDR_W-1:0]         out_addr,
  input  logic [LANES*DATA_W-1:0]   out_rdata,
  output logic [ADDR_W-1:0]         gold_addr,
  input  logic [LANES*DATA_W-1:0]   gold_rdata,
  output logic                      busy,
  output logic                      check_done,
  output logic                      pass,
  output logic                      timeout,
  output logic [CNT_W-1:0]          err_count,
  output logic [ADDR_W-1:0]         first_err_addr,
  output logic [LANE_W-1:0]         first_err_lane
);

  localparam int WD_W = clog2_min1(MAX_CYCLES);

  state_t              r_state, w_state_nxt;
  logic [DIM_W-1:0]    r_m, r_n, r_col, r_row;
  logic [WD_W-1:0]     r_wd;
  logic [ADDR_W-1:0]   r_addr, r_cmp_addr, r_first_addr;
  logic [LANE_W-1:0]   r_first_lane, w_first_lane;
  logic [CNT_W-1:0]    r_err;
  logic                r_timeout, r_first_seen, r_cmp_valid, r_cmp_last;
  logic [31:0]         w_row_words, w_valid_lanes;
  logic                w_empty, w_col_last, w_row_last, w_issue_last, w_wd_expire, w_go;
  logic [LANES-1:0]    w_lane_mask, w_mismatch;
  logic [CNT_W:0]      w_pop, w_err_sum;

  // Geometry from the latched dimensions; the word walk uses row/column counters
  // so the total word count m*row_words is never formed.
  assign w_row_words   = (32'(r_n) + 32'(LANES) - 32'd1) / 32'(LANES);
  assign w_valid_lanes = 32'(r_n) - (w_row_words - 32'd1) * 32'(LANES);
  assign w_empty       = (r_m == '0) || (r_n == '0);
  assign w_col_last    = (32'(r_col) + 32'd1) == w_row_words;
  assign w_row_last    = (32'(r_row) + 32'd1) == 32'(r_m);
  assign w_issue_last  = w_col_last && w_row_last;
  assign w_wd_expire   = (r_state == ST_WAIT_DONE) && (r_wd == WD_W'(MAX_CYCLES - 1));
  assign w_go          = (r_state == ST_WAIT_DONE) && (done_i || w_wd_expire);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_REPORT: if (start) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE:       if (w_go) w_state_nxt = w_empty ? ST_REPORT : ST_SCAN;
      ST_SCAN:            if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:           w_state_nxt = ST_REPORT;
      default:            w_state_nxt = ST_IDLE;
    endcase
  end

  // Only the last column word of a row carries padding lanes
  always_comb begin
    w_lane_mask = '1;
    for (int j = 0; j < LANES; j++) begin
      if (r_cmp_last && (32'(j) >= w_valid_lanes)) w_lane_mask[j] = 1'b0;
    end
  end

  gbuff_lane_cmp #(
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .REVERSE (REVERSE)
  ) u_lane_cmp (
    .i_out_word  (out_rdata),
    .i_gold_word (gold_rdata),
    .i_lane_mask (w_lane_mask),
    .o_mismatch  (w_mismatch)
  );

  // Descending walk so the lowest mismatching lane is the one left in w_first_lane
  always_comb begin
    w_pop        = '0;
    w_first_lane = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      w_pop = w_pop + (CNT_W+1)'(w_mismatch[j]);
      if (w_mismatch[j]) w_first_lane = LANE_W'(j);
    end
  end

  assign w_err_sum = {1'b0, r_err} + w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m          <= '0;
      r_n          <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_wd         <= '0;
      r_addr       <= '0;
      r_cmp_addr   <= '0;
      r_first_addr <= '0;
      r_first_lane <= '0;
      r_err        <= '0;
      r_timeout    <= 1'b0;
      r_first_seen <= 1'b0;
      r_cmp_valid  <= 1'b0;
      r_cmp_last   <= 1'b0;
    end else begin
      r_cmp_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_REPORT: begin
          if (start) begin
            r_m          <= m;
            r_n          <= n;
            r_wd         <= '0;
            r_err        <= '0;
            r_timeout    <= 1'b0;
            r_first_seen <= 1'b0;
            r_first_addr <= '0;
            r_first_lane <= '0;
          end
        end
        ST_WAIT_DONE: begin
          // done_i has priority over a watchdog expiry in the same cycle
          if (!done_i) begin
            if (w_wd_expire) r_timeout <= 1'b1;
            else             r_wd      <= r_wd + 1'b1;
          end
          if (w_go && !w_empty) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
          end
        end
        ST_SCAN: begin
          // Tag the issued address; its read data is compared next cycle
          r_cmp_valid <= 1'b1;
          r_cmp_addr  <= r_addr;
          r_cmp_last  <= w_col_last;
          if (!w_issue_last) begin
            r_addr <= r_addr + 1'b1;
            if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (r_cmp_valid) begin
        r_err <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
        if (!r_first_seen && (w_mismatch != '0)) begin
          r_first_seen <= 1'b1;
          r_first_addr <= r_cmp_addr;
          r_first_lane <= w_first_lane;
        end
      end
    end
  end

  assign out_addr       = r_addr;
  assign gold_addr      = r_addr;
  assign busy           = (r_state == ST_WAIT_DONE) || (r_state == ST_SCAN) || (r_state == ST_DRAIN);
  assign check_done     = (r_state == ST_REPORT);
  assign pass           = (r_state == ST_REPORT) && (r_err == '0) && !r_timeout;
  assign timeout        = r_timeout;
  assign err_count      = r_err;
  assign first_err_addr = r_first_addr;
  assign first_err_lane = r_first_lane;

endmodule

// File: tb/tb_gbuff_out_checker.sv
// tb/tb_gbuff_out_checker.sv - randomized self-checking bench for gbuff_out_checker
module tb_gbuff_out_checker;

  localparam int MAXC = 100;

  logic        clk = 1'b0;
  logic        rst_n, start, done_i;
  logic [3:0]  m, n;
  logic [7:0]  out_addr, gold_addr, first_err_addr;
  logic [31:0] out_rdata, gold_rdata;
  logic        busy, check_done, pass, timeout;
  logic [15:0] err_count;
  logic [1:0]  first_err_lane;

  logic [31:0] out_mem  [256];
  logic [31:0] gold_mem [256];

  int n_pass  = 0;
  int n_total = 0;
  int lat;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    out_rdata  <= out_mem[out_addr];
    gold_rdata <= gold_mem[gold_addr];
  end

  gbuff_out_checker #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .n(n), .done_i(done_i),
    .out_addr(out_addr), .out_rdata(out_rdata), .gold_addr(gold_addr), .gold_rdata(gold_rdata),
    .busy(busy), .check_done(check_done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr), .first_err_lane(first_err_lane)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] rev4(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic fill_clean();
    for (int a = 0; a < 256; a++) begin
      out_mem[a]  = $urandom;
      gold_mem[a] = rev4(out_mem[a]);
    end
  endtask

  // Reference: walk rows and column words, golden lane 3-j, padding lanes skipped
  task automatic model(input int mm, input int nn, output int ecnt, output int eaddr, output int elane);
    int rw, vl;
    logic [31:0] ow, gw;
    bit found;
    rw = (nn + 3) / 4;
    vl = nn - (rw - 1) * 4;
    ecnt = 0; eaddr = 0; elane = 0; found = 0;
    for (int r = 0; r < mm; r++)
      for (int c = 0; c < rw; c++) begin
        ow = out_mem[r*rw + c];
        gw = gold_mem[r*rw + c];
        for (int j = 0; j < 4; j++) begin
          if (c == rw - 1 && j >= vl) continue;
          if (ow[j*8 +: 8] != gw[(3-j)*8 +: 8]) begin
            ecnt++;
            if (!found) begin found = 1; eaddr = r*rw + c; elane = j; end
          end
        end
      end
  endtask

  task automatic run_check(input int mm, input int nn, input int done_delay,
                           input bit start_in_scan, output int latency);
    int w, ecnt, eaddr, elane;
    logic [7:0] addr_before;
    bit exp_to;
    model(mm, nn, ecnt, eaddr, elane);
    w = (nn == 0) ? 0 : mm * ((nn + 3) / 4);
    addr_before = out_addr;
    latency = 0;
    @(posedge clk); #1; start = 1'b1; m = 4'(mm); n = 4'(nn);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("armed_busy", busy, 1);
    chk("armed_no_done", check_done, 0);
    if (done_delay >= 0) begin
      exp_to = 0;
      repeat (done_delay) @(posedge clk);
      #1 done_i = 1'b1;
      @(posedge clk); latency++;
      #1 done_i = 1'b0;
    end else begin
      exp_to = 1;
      repeat (MAXC - 1) @(posedge clk);
      @(negedge clk);
      chk("timeout_early", timeout, 0);
      chk("wait_busy", busy, 1);
      @(posedge clk); #1;
    end
    if (w > 0) begin
      for (int k = 0; k < w; k++) begin
        @(negedge clk);
        chk("scan_addr", out_addr, k);
        chk("scan_gold_addr", gold_addr, k);
        chk("scan_busy", busy, 1);
        chk("scan_timeout", timeout, exp_to);
        if (start_in_scan && k == 0) start = 1'b1;
        @(posedge clk); latency++;
        #1 start = 1'b0;
      end
      @(negedge clk);
      chk("drain_busy", busy, 1);
      chk("drain_not_done", check_done, 0);
      @(posedge clk); latency++;
    end
    @(negedge clk);
    chk("report_done", check_done, 1);
    chk("report_busy", busy, 0);
    chk("report_timeout", timeout, exp_to);
    chk("report_err", err_count, ecnt);
    chk("report_first_addr", first_err_addr, eaddr);
    chk("report_first_lane", first_err_lane, elane);
    chk("report_pass", pass, (ecnt == 0 && !exp_to));
    if (w == 0) chk("empty_addr_held", out_addr, addr_before);
    repeat (3) @(negedge clk);
    chk("hold_done", check_done, 1);
    chk("hold_err", err_count, ecnt);
    chk("hold_addr", out_addr, (w > 0) ? 32'(w - 1) : 32'(addr_before));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; done_i = 1'b0; m = '0; n = '0;
    fill_clean();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_gold_addr", gold_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_check_done", check_done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first_addr", first_err_addr, 0);
    chk("rst_first_lane", first_err_lane, 0);

    // 1: clean 4x4, latency W+2 = 6
    fill_clean();
    run_check(4, 4, 3, 0, lat);
    chk("t1_latency", lat, 6);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_count, 0);

    // 2: one flipped lane
    fill_clean();
    out_mem[5][23:16] = out_mem[5][23:16] ^ 8'h10;
    run_check(4, 8, 2, 0, lat);
    chk("t2_err", err_count, 1);
    chk("t2_addr", first_err_addr, 5);
    chk("t2_lane", first_err_lane, 2);
    chk("t2_pass", pass, 0);

    // 3: padding lanes masked, then a real lane corrupted
    fill_clean();
    for (int a = 1; a < 6; a += 2) out_mem[a][31:16] = out_mem[a][31:16] ^ 16'hA5C3;
    run_check(3, 6, 1, 0, lat);
    chk("t3a_pass", pass, 1);
    chk("t3a_err", err_count, 0);
    for (int a = 1; a < 6; a += 2) out_mem[a][15:8] = out_mem[a][15:8] ^ 8'h01;
    run_check(3, 6, 1, 0, lat);
    chk("t3b_err", err_count, 3);
    chk("t3b_addr", first_err_addr, 1);
    chk("t3b_lane", first_err_lane, 1);

    // 4: watchdog
    fill_clean();
    run_check(2, 4, -1, 0, lat);
    chk("t4_timeout", timeout, 1);
    chk("t4_pass", pass, 0);

    // 5: reset mid-scan
    fill_clean();
    @(posedge clk); #1; start = 1'b1; m = 4'd4; n = 4'd8;
    @(posedge clk); #1; start = 1'b0; done_i = 1'b1;
    @(posedge clk); #1; done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_addr", out_addr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", check_done, 0);
    chk("t5_pass", pass, 0);
    chk("t5_err", err_count, 0);
    run_check(4, 8, 5, 0, lat);
    chk("t5_recheck_pass", pass, 1);

    // 6: empty matrix, and start ignored during scan
    run_check(0, 5, 2, 0, lat);
    chk("t6_latency", lat, 1);
    chk("t6_pass", pass, 1);
    out_mem[3][7:0] = out_mem[3][7:0] ^ 8'h80;
    run_check(2, 7, 0, 1, lat);
    chk("t6_scan_start_err", err_count, 1);

    for (int it = 0; it < 25; it++) begin
      int mm, nn;
      fill_clean();
      for (int a = 0; a < 64; a++)
        if ($urandom_range(0, 7) == 0) begin
          int j;
          j = $urandom_range(0, 3);
          out_mem[a][j*8 +: 8] = out_mem[a][j*8 +: 8] ^ 8'(1 << $urandom_range(0, 7));
        end
      mm = $urandom_range(0, 15);
      nn = $urandom_range(0, 15);
      run_check(mm, nn, $urandom_range(0, 10), 1'($urandom_range(0, 1)), lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
